// File: rtl/uart_tx_pkg.sv
// UART TX shared definitions: FSM encoding and line levels.
// Also a counter-width helper for the serializer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Parallel request side and serial line of the UART TX frame controller.
// The master drives words in; the slave drives the line and Busy.
interface uart_tx_frame_ctrl_if #(
  parameter int Data_WD = 8
);

  logic [Data_WD-1:0] P_DATA;
  logic               Data_Valid;
  logic               PAR_EN;
  logic               par_bit;
  logic               TX_OUT;
  logic               Busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output par_bit,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  par_bit,
    output TX_OUT,
    output Busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART TX data phase.
// ser_data is the bit the line must carry in the following cycle.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int Data_WD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift_en,
  input  logic [Data_WD-1:0] data,
  output logic               ser_data,
  output logic               ser_done
);

  localparam int CW = cnt_w(Data_WD);
  localparam logic [CW-1:0] LAST = CW'(Data_WD - 1);

  logic [Data_WD-1:0] shift_q;
  logic [CW-1:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= data;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[Data_WD-1:1]};
      if (cnt_q != LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // While shifting, the line register is loaded with the upcoming bit
  assign ser_data = shift_en ? shift_q[1] : shift_q[0];
  assign ser_done = shift_en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: start, LSB-first data, optional parity, stop.
// TX_OUT and Busy are registered from next-state values.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int Data_WD = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_frame_ctrl_if.slave  bus
);

  state_t state_q;
  state_t state_d;
  logic   par_en_q;
  logic   tx_q;
  logic   tx_d;
  logic   busy_q;
  logic   load;
  logic   shift_en;
  logic   ser_data;
  logic   ser_done;

  uart_tx_serializer #(
    .Data_WD (Data_WD)
  ) u_ser (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .shift_en (shift_en),
    .data     (bus.P_DATA),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      par_en_q <= 1'b0;
      tx_q     <= IDLE_LVL;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      if (load) begin
        par_en_q <= bus.PAR_EN;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START: state_d = DATA;
      DATA: begin
        shift_en = 1'b1;
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line level for the cycle being entered
  always_comb begin
    tx_d = IDLE_LVL;
    unique case (1'b1)
      (state_d == START):  tx_d = START_LVL;
      (state_d == DATA):   tx_d = ser_data;
      (state_d == PARITY): tx_d = bus.par_bit;
      (state_d == STOP):   tx_d = STOP_LVL;
      default:             tx_d = IDLE_LVL;
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule
